// File: rtl/buffer_sequencer_pkg.sv
// Shared encodings for the buffer sequencer: FSM states, line-state codes S0..S7
// and the line-state step helper.
package buffer_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [2:0] LS_S0 = 3'd0;
    localparam logic [2:0] LS_S1 = 3'd1;
    localparam logic [2:0] LS_S2 = 3'd2;
    localparam logic [2:0] LS_S3 = 3'd3;
    localparam logic [2:0] LS_S4 = 3'd4;
    localparam logic [2:0] LS_S5 = 3'd5;
    localparam logic [2:0] LS_S6 = 3'd6;
    localparam logic [2:0] LS_S7 = 3'd7;

    // S7 rolls back to S0 through the natural 3-bit wrap
    function automatic logic [2:0] ls_next(input logic [2:0] s);
        return s + 3'd1;
    endfunction

endpackage

// File: rtl/buffer_sequencer_line_state_counter.sv
// Output-phase S0..S7 cycler; clear has priority over enable.
module line_state_counter
    import buffer_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       en_i,
    input  logic       clr_i,
    output logic [2:0] state_o
);

    logic [2:0] state_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    state_q <= LS_S0;
        else if (clr_i) state_q <= LS_S0;
        else if (en_i)  state_q <= ls_next(state_q);
    end

    assign state_o = state_q;

endmodule

// File: rtl/buffer_sequencer.sv
// Line buffer sequencer: fills one vbuf bank from ZBT, then drains it pixel by pixel.
// Optional macro BUFSEQ_ABORT_EN: line_start while busy restarts the line on the other bank.
module buffer_sequencer
    import buffer_sequencer_pkg::*;
#(
    parameter int LINE_WORDS  = 360,
    parameter int LINE_PIXELS = 720
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        line_start,
    input  logic        zbt_valid,
    output logic        zbt_rd_req,
    output logic [10:0] vbuf_addr,
    output logic        vbuf_we,
    output logic [9:0]  ybuf_addr,
    output logic        ybuf_we,
    output logic [2:0]  line_state,
    output logic        busy,
    output logic        line_done
);

    localparam logic [9:0] WORD_LAST = 10'(LINE_WORDS - 1);
    localparam logic [9:0] PIX_LAST  = 10'(LINE_PIXELS - 1);
    localparam logic [8:0] WADDR_MAX = 9'h1FF;

    seq_state_e state_q, state_d;
    logic       bank_q, bank_d;
    logic [8:0] waddr_q, waddr_d;
    logic       pair_q, pair_d;
    logic [9:0] yaddr_q, yaddr_d;
    logic [9:0] wcnt_q, wcnt_d;
    logic       accept, restart, ls_clr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            bank_q  <= 1'b0;
            waddr_q <= '0;
            pair_q  <= 1'b0;
            yaddr_q <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            waddr_q <= waddr_d;
            pair_q  <= pair_d;
            yaddr_q <= yaddr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        waddr_d = waddr_q;
        pair_d  = pair_q;
        yaddr_d = yaddr_q;
        wcnt_d  = wcnt_q;
        restart = 1'b0;
        // zbt_rd_req is high for all of FILL, so this also drops stray valids
        accept  = (state_q == ST_FILL) && zbt_valid;

        case (state_q)
            ST_IDLE: restart = line_start;
            ST_FILL: begin
                if (accept) begin
                    if (wcnt_q == WORD_LAST) begin
                        state_d = ST_DRAIN;
                        waddr_d = '0;
                        pair_d  = 1'b0;
                        yaddr_d = '0;
                    end else begin
                        wcnt_d  = wcnt_q + 10'd1;
                        waddr_d = (waddr_q == WADDR_MAX) ? waddr_q : waddr_q + 9'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // two pixels per vbuf word: pair bit toggles, word advances after odd pixel
                pair_d = ~pair_q;
                if (pair_q && waddr_q != WADDR_MAX) waddr_d = waddr_q + 9'd1;
                if (yaddr_q == PIX_LAST) state_d = ST_DONE;
                else                     yaddr_d = yaddr_q + 10'd1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                restart = line_start;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef BUFSEQ_ABORT_EN
        if ((state_q == ST_FILL || state_q == ST_DRAIN) && line_start) restart = 1'b1;
`endif

        if (restart) begin
            state_d = ST_FILL;
            bank_d  = ~bank_q;
            wcnt_d  = '0;
            waddr_d = '0;
            pair_d  = 1'b0;
            yaddr_d = '0;
        end
    end

    // Counter restarts at S0 on DRAIN entry and reads S0 everywhere outside DRAIN
    assign ls_clr = (state_q != ST_DRAIN) || (state_d != ST_DRAIN);

    line_state_counter u_lsc (
        .clk     (clk),
        .resetn  (resetn),
        .en_i    (state_q == ST_DRAIN),
        .clr_i   (ls_clr),
        .state_o (line_state)
    );

    assign zbt_rd_req = (state_q == ST_FILL);
    assign vbuf_we    = accept;
    assign ybuf_we    = accept && !bank_q;
    assign vbuf_addr  = {bank_q, waddr_q, pair_q};
    assign ybuf_addr  = yaddr_q;
    assign busy       = (state_q != ST_IDLE);
    assign line_done  = (state_q == ST_DONE);

endmodule
